hme_ip_rgmii_tx_mspd: RTL and testbench

Multi-speed RGMII transmit formatter for 10, 100 and 1000 Mb/s.
- Takes a GMII byte stream clocked by `clk_eth` (125 MHz) and produces registered rising/falling-edge bit pairs for the TXC, TX_CTL and TXD[3:0] pads.
- Those pairs feed one `ddr_tx` output cell per pad. Each cell's `din[1]` is the rising-edge half and `din[0]` is the falling-edge half.
- At 10/100 it divides TXC in-fabric, serialises nibbles, and paces the MAC with a clock-enable.
- Sits between the MAC TX path and the pad ring, replacing the fixed-gigabit formatter.

---
 rtl/hme_ip_rgmii_tx_mspd.sv | 186 ++++++++++++++++++
 tb/tb_hme_ip_rgmii_tx_mspd.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hme_ip_rgmii_tx_mspd.sv
// Multi-speed RGMII transmit formatter (10/100/1000 Mb/s).
// Turns a GMII byte stream on clk_eth into registered {rise, fall} pairs
// for the TXC, TX_CTL and TXD[3:0] DDR output cells. At 10/100 the TXC
// clock is divided in fabric, bytes are sent as two nibbles (low first)
// and the MAC is paced with o_tx_ce.
//
// Handshake: o_tx_ce is a registered strobe. The MAC holds gmii_tx_en,
// gmii_txd and gmii_tx_er stable through any cycle where o_tx_ce=1; the
// byte is consumed at the edge ending that cycle, and the MAC may present
// the next byte from that same edge. At 1000M o_tx_ce stays high.
module hme_ip_rgmii_tx_mspd #(
  parameter int         DIV_100   = 5,
  parameter int         DIV_10    = 50,
  parameter bit         ER_EN     = 1'b1,
  parameter logic [1:0] SPEED_RST = 2'b10
) (
  input  logic       clk_eth,
  input  logic       rst,
  input  logic [1:0] i_speed,
  input  logic       gmii_tx_en,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_er,
  output logic       o_tx_ce,
  output logic [1:0] o_speed_act,
  output logic [1:0] o_txc_d,
  output logic [1:0] o_ctl_d,
  output logic [3:0] o_txd_r,
  output logic [3:0] o_txd_f
);

  localparam int DMAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CW   = $clog2(DMAX);

  localparam logic [CW-1:0] D100_M1 = CW'(DIV_100 - 1);
  localparam logic [CW-1:0] D10_M1  = CW'(DIV_10 - 1);
  localparam logic [CW-1:0] U100_M1 = CW'((DIV_100 + 1) / 2 - 1);
  localparam logic [CW-1:0] U10_M1  = CW'((DIV_10 + 1) / 2 - 1);

  // TXC halves for a given divider phase: high for the first half period.
  function automatic logic [1:0] txc_pat(input logic [CW-1:0] c, input int d);
    int ci;
    ci = int'(c);
    return {((2 * ci) < d), ((2 * ci + 1) < d)};
  endfunction

  // TX_CTL pair: rise carries TX_EN, fall carries TX_EN^TX_ER (or TX_EN).
  function automatic logic [1:0] ctl_fn(input logic en, input logic er);
    return {en, (ER_EN ? (en ^ er) : en)};
  endfunction

  logic [CW-1:0] cnt, cnt_n;
  logic          ph, ph_n;
  logic          run, run_n;
  logic [3:0]    hold_nib, hold_nib_n;
  logic          hold_en, hold_en_n;
  logic          hold_er, hold_er_n;
  logic [1:0]    spd_n, txc_n, ctl_n;
  logic [3:0]    txd_r_n, txd_f_n;
  logic          ce_n;
  logic          do_switch;

  logic [1:0]    req_spd;
  logic          act_gig, req_gig;
  logic [CW-1:0] d_m1, u_m1;
  int            d_cur, d_req;
  logic          wrap, upd;

  // Decode the requested speed (11 means 1000M) and current divider.
  assign req_spd = (i_speed == 2'b11) ? 2'b10 : i_speed;
  assign act_gig = o_speed_act[1];
  assign req_gig = req_spd[1];
  assign d_m1    = (o_speed_act == 2'b01) ? D100_M1 : D10_M1;
  assign u_m1    = (o_speed_act == 2'b01) ? U100_M1 : U10_M1;
  assign d_cur   = (o_speed_act == 2'b01) ? DIV_100 : DIV_10;
  assign d_req   = (req_spd == 2'b01) ? DIV_100 : DIV_10;
  assign wrap    = (cnt == d_m1);
  assign upd     = (cnt == u_m1);

  // Next-state and next-output logic for all modes and speed switching.
  always_comb begin
    spd_n      = o_speed_act;
    cnt_n      = cnt;
    ph_n       = ph;
    run_n      = 1'b1;
    hold_nib_n = hold_nib;
    hold_en_n  = hold_en;
    hold_er_n  = hold_er;
    txc_n      = o_txc_d;
    ctl_n      = o_ctl_d;
    txd_r_n    = o_txd_r;
    txd_f_n    = o_txd_f;
    ce_n       = 1'b0;
    do_switch  = 1'b0;

    if (act_gig) begin
      // 1000M: one register stage, TXC is the clock itself.
      cnt_n   = '0;
      ph_n    = 1'b0;
      ce_n    = 1'b1;
      txc_n   = 2'b10;
      txd_r_n = gmii_txd[3:0];
      txd_f_n = gmii_txd[7:4];
      ctl_n   = ctl_fn(gmii_tx_en, gmii_tx_er);
      // Idle only when nothing is arriving and nothing was just sent.
      if ((req_spd != o_speed_act) && !gmii_tx_en && !o_ctl_d[1]) begin
        do_switch = 1'b1;
      end
    end else if (!run) begin
      // First cycle after reset: park at phase 0 so the first TXC high
      // half is full length.
      cnt_n = '0;
      txc_n = txc_pat('0, d_cur);
      ce_n  = (u_m1 == '0);
    end else begin
      cnt_n = wrap ? '0 : cnt + 1'b1;
      if (upd) begin
        if (!ph) begin
          txd_r_n    = gmii_txd[3:0];
          txd_f_n    = gmii_txd[3:0];
          ctl_n      = ctl_fn(gmii_tx_en, gmii_tx_er);
          hold_nib_n = gmii_txd[7:4];
          hold_en_n  = gmii_tx_en;
          hold_er_n  = gmii_tx_er;
          ph_n       = 1'b1;
        end else begin
          txd_r_n = hold_nib;
          txd_f_n = hold_nib;
          ctl_n   = ctl_fn(hold_en, hold_er);
          ph_n    = 1'b0;
        end
      end
      ce_n  = (cnt_n == u_m1) && !ph_n;
      txc_n = txc_pat(cnt_n, d_cur);
      // Switch only on a byte boundary after an idle byte has gone out.
      if (wrap && !ph && !hold_en && (req_spd != o_speed_act)) begin
        do_switch = 1'b1;
      end
    end

    if (do_switch) begin
      spd_n      = req_spd;
      cnt_n      = '0;
      ph_n       = 1'b0;
      hold_nib_n = 4'h0;
      hold_en_n  = 1'b0;
      hold_er_n  = 1'b0;
      ctl_n      = 2'b00;
      txd_r_n    = 4'h0;
      txd_f_n    = 4'h0;
      txc_n      = req_gig ? 2'b10 : txc_pat('0, d_req);
      ce_n       = req_gig ? 1'b1 : (((d_req + 1) / 2) == 1);
    end
  end

  // State and output registers; asynchronous reset to the idle pattern.
  always_ff @(posedge clk_eth or posedge rst) begin
    if (rst) begin
      o_speed_act <= SPEED_RST;
      cnt         <= '0;
      ph          <= 1'b0;
      run         <= 1'b0;
      hold_nib    <= 4'h0;
      hold_en     <= 1'b0;
      hold_er     <= 1'b0;
      o_txc_d     <= 2'b00;
      o_ctl_d     <= 2'b00;
      o_txd_r     <= 4'h0;
      o_txd_f     <= 4'h0;
      o_tx_ce     <= 1'b0;
    end else begin
      o_speed_act <= spd_n;
      cnt         <= cnt_n;
      ph          <= ph_n;
      run         <= run_n;
      hold_nib    <= hold_nib_n;
      hold_en     <= hold_en_n;
      hold_er     <= hold_er_n;
      o_txc_d     <= txc_n;
      o_ctl_d     <= ctl_n;
      o_txd_r     <= txd_r_n;
      o_txd_f     <= txd_f_n;
      o_tx_ce     <= ce_n;
    end
  end

endmodule

// File: tb/tb_hme_ip_rgmii_tx_mspd.sv
// Bench for hme_ip_rgmii_tx_mspd: two instances (TX_ER folded / ignored)
// share one stimulus stream and are compared every cycle against a
// closed-form model of the pad patterns, plus directed literal checks.
module tb_hme_ip_rgmii_tx_mspd;

  localparam int         MAXC      = 20000;
  localparam logic [1:0] SPEED_RST = 2'b10;
  localparam int         DIV_100   = 5;
  localparam int         DIV_10    = 50;

  logic       clk_eth = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_speed = 2'b10;
  logic       gmii_tx_en = 1'b0;
  logic [7:0] gmii_txd = 8'h00;
  logic       gmii_tx_er = 1'b0;

  logic       ce1, ce2;
  logic [1:0] spd1, spd2, txc1, txc2, ctl1, ctl2;
  logic [3:0] txdr1, txdr2, txdf1, txdf2;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #4 clk_eth = ~clk_eth;

  hme_ip_rgmii_tx_mspd #(.DIV_100(DIV_100), .DIV_10(DIV_10), .ER_EN(1'b1), .SPEED_RST(SPEED_RST)) dut (
    .clk_eth(clk_eth), .rst(rst), .i_speed(i_speed), .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd), .gmii_tx_er(gmii_tx_er), .o_tx_ce(ce1), .o_speed_act(spd1),
    .o_txc_d(txc1), .o_ctl_d(ctl1), .o_txd_r(txdr1), .o_txd_f(txdf1));

  hme_ip_rgmii_tx_mspd #(.DIV_100(DIV_100), .DIV_10(DIV_10), .ER_EN(1'b0), .SPEED_RST(SPEED_RST)) dut_ne (
    .clk_eth(clk_eth), .rst(rst), .i_speed(i_speed), .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd), .gmii_tx_er(gmii_tx_er), .o_tx_ce(ce2), .o_speed_act(spd2),
    .o_txc_d(txc2), .o_ctl_d(ctl2), .o_txd_r(txdr2), .o_txd_f(txdf2));

  wire [14:0] out1 = {ce1, spd1, txc1, ctl1, txdr1, txdf1};
  wire [14:0] out2 = {ce2, spd2, txc2, ctl2, txdr2, txdf2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] txd_h [0:MAXC-1];
  bit         en_h  [0:MAXC-1];
  bit         er_h  [0:MAXC-1];
  int         t = 0;
  bit         in_rst = 1'b1;
  logic [1:0] m_spd = SPEED_RST;
  int         m_seg = 0;
  bit         m_from_rst = 1'b1;
  bit         ce_q = 1'b0;

  function automatic logic [1:0] ctlf(input bit en, input bit er, input bit er_en);
    return {en, (er_en ? (en ^ er) : en)};
  endfunction

  function automatic int div_of(input logic [1:0] s);
    return (s == 2'b01) ? DIV_100 : DIV_10;
  endfunction

  // Outputs expected during cycle tt, from the rules of each mode.
  function automatic logic [14:0] model_out(input int tt, input bit er_en);
    int d, u, t0, n, c, k, j, s;
    logic [1:0] txc, ctl;
    logic [3:0] nib;
    logic ce;
    if (in_rst) return {1'b0, SPEED_RST, 12'h000};
    if (m_spd[1]) begin
      if (tt == m_seg)
        return m_from_rst ? {1'b0, m_spd, 12'h000} : {1'b1, m_spd, 2'b10, 10'h000};
      return {1'b1, m_spd, 2'b10, ctlf(en_h[tt-1], er_h[tt-1], er_en),
              txd_h[tt-1][3:0], txd_h[tt-1][7:4]};
    end
    d  = div_of(m_spd);
    u  = (d + 1) / 2;
    t0 = m_seg + (m_from_rst ? 1 : 0);
    if (tt < t0) return {1'b0, m_spd, 12'h000};
    n   = tt - t0;
    c   = n % d;
    k   = n / d;
    ce  = (c == u - 1) && (k % 2 == 0);
    txc = {((2 * c) < d), ((2 * c + 1) < d)};
    nib = 4'h0;
    ctl = 2'b00;
    if (n >= u) begin
      j = (n - u) / d;
      if (j % 2 == 0) begin
        s   = t0 + j * d + u - 1;
        nib = txd_h[s][3:0];
      end else begin
        s   = t0 + (j - 1) * d + u - 1;
        nib = txd_h[s][7:4];
      end
      ctl = ctlf(en_h[s], er_h[s], er_en);
    end
    return {ce, m_spd, txc, ctl, nib, nib};
  endfunction

  // Whether the edge ending cycle tt applies a pending speed request.
  function automatic bit model_switch(input int tt, input logic [14:0] e, input logic [1:0] req);
    int d, u, t0, n, c, k;
    if (in_rst || rst || (req == m_spd)) return 1'b0;
    if (m_spd[1]) return !en_h[tt] && !e[9];
    d  = div_of(m_spd);
    u  = (d + 1) / 2;
    t0 = m_seg + (m_from_rst ? 1 : 0);
    if (tt < t0) return 1'b0;
    n = tt - t0;
    c = n % d;
    k = n / d;
    return (c == d - 1) && (k % 2 == 1) && !en_h[t0 + (k - 1) * d + u - 1];
  endfunction

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk_eth) begin
    logic [14:0] e1, e0;
    logic [1:0] req;
    if (t >= MAXC - 1) begin
      $display("FAIL cycle_budget actual=%0d required<%0d", t, MAXC - 1);
      $fatal(1);
    end
    if (rst) begin
      in_rst = 1'b1;
      m_spd  = SPEED_RST;
    end else if (in_rst) begin
      in_rst     = 1'b0;
      m_seg      = t;
      m_from_rst = 1'b1;
      m_spd      = SPEED_RST;
    end
    e1 = model_out(t, 1'b1);
    e0 = model_out(t, 1'b0);
    chk("pads_er_en1", out1, e1);
    chk("pads_er_en0", out2, e0);
    txd_h[t] = gmii_txd;
    en_h[t]  = gmii_tx_en;
    er_h[t]  = gmii_tx_er;
    ce_q     = ce1;
    req = (i_speed == 2'b11) ? 2'b10 : i_speed;
    if (model_switch(t, e1, req)) begin
      m_spd      = req;
      m_seg      = t + 1;
      m_from_rst = 1'b0;
    end
    t++;
  end

  // ---------------- driver tasks ----------------
  // Returns at posedge+1 just after the edge that consumed the byte.
  task automatic wait_ce();
    int n = 0;
    do begin
      @(posedge clk_eth); #1;
      n++;
    end while (!ce_q && n < 400);
    chk("ce_within_budget", ce_q, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit en, input bit er);
    gmii_txd   = b;
    gmii_tx_en = en;
    gmii_tx_er = er;
    wait_ce();
  endtask

  task automatic rand_frame(input int len, input bit with_er);
    for (int i = 0; i < len; i++)
      send_byte(8'($urandom_range(0, 255)), 1'b1, with_er && ($urandom_range(0, 3) == 0));
    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
      send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic wait_speed(input logic [1:0] s);
    int n = 0;
    @(negedge clk_eth);
    while (spd1 !== s && n < 300) begin
      @(negedge clk_eth);
      n++;
    end
    chk("speed_switch", spd1, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] txc_seq [0:4];
    int m;
    txc_seq[0] = 2'b11; txc_seq[1] = 2'b11; txc_seq[2] = 2'b10;
    txc_seq[3] = 2'b00; txc_seq[4] = 2'b00;

    repeat (3) @(negedge clk_eth);
    chk("reset_values", out1, {1'b0, SPEED_RST, 12'h000});
    @(posedge clk_eth); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk_eth); #1; end

    // 1000M directed bytes 0x5D, 0xA3
    gmii_tx_en = 1'b1; gmii_txd = 8'h5D;
    @(posedge clk_eth); #1;
    gmii_txd = 8'hA3;
    @(negedge clk_eth);
    chk("g_5d_txd", {txdr1, txdf1}, 8'hD5);
    chk("g_5d_ctl", ctl1, 2'b11);
    chk("g_5d_txc", txc1, 2'b10);
    @(posedge clk_eth); #1;
    gmii_tx_en = 1'b0;
    @(negedge clk_eth);
    chk("g_a3_txd", {txdr1, txdf1}, 8'h3A);
    @(posedge clk_eth); #1;
    for (int f = 0; f < 3; f++) rand_frame($urandom_range(2, 6), 1'b1);

    // mid-frame request for 100M: deferred until the frame is over
    i_speed = 2'b01;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    chk("speed_held_in_frame", spd1, 2'b10);
    gmii_tx_en = 1'b0;
    wait_speed(2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("txc_100m_seq", txc1, txc_seq[i]);
      @(negedge clk_eth);
    end

    // 100M byte 0x5D: low nibble one period, then high nibble
    @(posedge clk_eth); #1;
    send_byte(8'h5D, 1'b1, 1'b0);
    @(negedge clk_eth);
    chk("m_5d_low", {txdr1, txdf1}, 8'hDD);
    repeat (5) @(negedge clk_eth);
    chk("m_5d_high", {txdr1, txdf1}, 8'h55);

    // TX_ER during a nibble pair at 100M
    @(posedge clk_eth); #1;
    send_byte(8'h96, 1'b1, 1'b1);
    @(negedge clk_eth);
    chk("er_low_en1", ctl1, 2'b10);
    chk("er_low_en0", ctl2, 2'b11);
    repeat (5) @(negedge clk_eth);
    chk("er_high_en1", ctl1, 2'b10);
    chk("er_high_en0", ctl2, 2'b11);
    @(posedge clk_eth); #1;
    send_byte(8'h00, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) rand_frame($urandom_range(2, 4), 1'b1);

    // request that reverts before it can apply is dropped
    send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    i_speed = 2'b00;
    send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    i_speed = 2'b01;
    send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    chk("revert_dropped", spd1, 2'b01);

    // 11 means 1000M, then on to 10M
    i_speed = 2'b11;
    gmii_tx_en = 1'b0;
    wait_speed(2'b10);
    i_speed = 2'b00;
    wait_speed(2'b00);
    m = 0;
    while (!ce1 && m < 300) begin @(negedge clk_eth); m++; end
    m = 0;
    do begin @(negedge clk_eth); m++; end while (!ce1 && m < 300);
    chk("ce_period_10m", m, 100);
    @(posedge clk_eth); #1;
    for (int i = 0; i < 3; i++)
      send_byte(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)));

    // reset in the middle of a byte at 10M
    send_byte(8'h3C, 1'b1, 1'b0);
    repeat (30) @(negedge clk_eth);
    @(posedge clk_eth); #1;
    rst = 1'b1;
    #1;
    chk("rst_async", out1, {1'b0, SPEED_RST, 12'h000});
    repeat (3) begin @(posedge clk_eth); #1; end
    rst = 1'b0;
    gmii_tx_en = 1'b0;
    i_speed = SPEED_RST;
    @(negedge clk_eth);
    chk("speed_after_rst", spd1, SPEED_RST);
    @(posedge clk_eth); #1;
    for (int f = 0; f < 3; f++) rand_frame($urandom_range(2, 8), 1'b1);

    repeat (5) @(negedge clk_eth);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
